// File: rtl/axi4lite2wb_bridge.sv
// AXI4-Lite slave to pipelined Wishbone master bridge. One transaction in flight,
// round-robin read/write arbitration, and a Wishbone timeout that returns SLVERR.
module axi4lite2wb_bridge #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic [2:0]              AWPROT,
   input  logic                    WVALID,
   output logic                    WREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   output logic                    BVALID,
   input  logic                    BREADY,
   output logic [1:0]              BRESP,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic [2:0]              ARPROT,
   output logic                    RVALID,
   input  logic                    RREADY,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    CYC,
   output logic                    STB,
   output logic                    WE,
   output logic [ADDR_WIDTH-1:0]   ADDR,
   output logic [DATA_WIDTH-1:0]   WB_WDATA,
   output logic [DATA_WIDTH/8-1:0] SEL,
   input  logic                    STALL,
   input  logic                    ACK,
   input  logic                    ERR,
   input  logic [DATA_WIDTH-1:0]   WB_RDATA
);

   localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [2:0] {StIdle, StWbReq, StWbWait, StBResp, StRResp} state_e;

   state_e                 state_q, state_d;
   logic                   aw_hold_q, aw_hold_d, w_hold_q, w_hold_d;
   logic [ADDR_WIDTH-1:0]  aw_addr_q, aw_addr_d;
   logic [DATA_WIDTH-1:0]  w_data_q, w_data_d;
   logic [SEL_WIDTH-1:0]   w_strb_q, w_strb_d;
   logic                   rd_prio_q, rd_prio_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  wb_wdata_q, wb_wdata_d;
   logic [SEL_WIDTH-1:0]   sel_q, sel_d;
   logic                   bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [1:0]             bresp_q, bresp_d, rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

   logic rd_sel, aw_hs, w_hs, wb_done, wb_ok;
   logic [1:0] wb_resp;

   logic unused_prot;
   assign unused_prot = ^{AWPROT, ARPROT};

   always_comb begin
      state_d    = state_q;
      aw_hold_d  = aw_hold_q;
      w_hold_d   = w_hold_q;
      aw_addr_d  = aw_addr_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      rd_prio_d  = rd_prio_q;
      cnt_d      = cnt_q;
      cyc_d      = cyc_q;
      stb_d      = stb_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wb_wdata_d = wb_wdata_q;
      sel_d      = sel_q;
      bvalid_d   = bvalid_q;
      rvalid_d   = rvalid_q;
      bresp_d    = bresp_q;
      rresp_d    = rresp_q;
      rdata_d    = rdata_q;
      rd_sel     = 1'b0;
      aw_hs      = 1'b0;
      w_hs       = 1'b0;
      wb_done    = 1'b0;
      wb_ok      = 1'b0;
      wb_resp    = 2'b00;
      AWREADY    = 1'b0;
      WREADY     = 1'b0;
      ARREADY    = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A read only wins over a simultaneous write request when it holds priority.
            rd_sel  = ARVALID & ~aw_hold_q & ~w_hold_q & (rd_prio_q | (~AWVALID & ~WVALID));
            ARREADY = rd_sel;
            AWREADY = ~aw_hold_q & ~rd_sel;
            WREADY  = ~w_hold_q & ~rd_sel;
            aw_hs   = AWVALID & AWREADY;
            w_hs    = WVALID & WREADY;
            if (rd_sel) begin
               state_d = StWbReq;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = ARADDR;
               sel_d   = '1;
            end else begin
               if (aw_hs) begin
                  aw_hold_d = 1'b1;
                  aw_addr_d = AWADDR;
               end
               if (w_hs) begin
                  w_hold_d = 1'b1;
                  w_data_d = WDATA;
                  w_strb_d = WSTRB;
               end
               if ((aw_hold_q | aw_hs) & (w_hold_q | w_hs)) begin
                  state_d    = StWbReq;
                  cyc_d      = 1'b1;
                  stb_d      = 1'b1;
                  we_d       = 1'b1;
                  addr_d     = aw_hold_q ? aw_addr_q : AWADDR;
                  wb_wdata_d = w_hold_q ? w_data_q : WDATA;
                  sel_d      = w_hold_q ? w_strb_q : WSTRB;
               end
            end
         end
         StWbReq: begin
            if (!STALL) begin
               stb_d = 1'b0;
               cnt_d = '0;
               if (ACK | ERR) wb_done = 1'b1;
               else           state_d = StWbWait;
            end
         end
         StWbWait: begin
            if (ACK | ERR) begin
               wb_done = 1'b1;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
               wb_done = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StBResp: begin
            if (BREADY) begin
               bvalid_d  = 1'b0;
               aw_hold_d = 1'b0;
               w_hold_d  = 1'b0;
               rd_prio_d = 1'b1;
               state_d   = StIdle;
            end
         end
         StRResp: begin
            if (RREADY) begin
               rvalid_d  = 1'b0;
               rd_prio_d = 1'b0;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // ERR dominates ACK; a timeout arrives here with neither asserted.
      if (wb_done) begin
         wb_ok   = ACK & ~ERR;
         wb_resp = wb_ok ? 2'b00 : 2'b10;
         cyc_d   = 1'b0;
         if (we_q) begin
            bvalid_d = 1'b1;
            bresp_d  = wb_resp;
            state_d  = StBResp;
         end else begin
            rvalid_d = 1'b1;
            rresp_d  = wb_resp;
            rdata_d  = wb_ok ? WB_RDATA : '0;
            state_d  = StRResp;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= StIdle;
         aw_hold_q  <= 1'b0;
         w_hold_q   <= 1'b0;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         rd_prio_q  <= 1'b0;
         cnt_q      <= '0;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wb_wdata_q <= '0;
         sel_q      <= '0;
         bvalid_q   <= 1'b0;
         rvalid_q   <= 1'b0;
         bresp_q    <= 2'b00;
         rresp_q    <= 2'b00;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         aw_hold_q  <= aw_hold_d;
         w_hold_q   <= w_hold_d;
         aw_addr_q  <= aw_addr_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         rd_prio_q  <= rd_prio_d;
         cnt_q      <= cnt_d;
         cyc_q      <= cyc_d;
         stb_q      <= stb_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wb_wdata_q <= wb_wdata_d;
         sel_q      <= sel_d;
         bvalid_q   <= bvalid_d;
         rvalid_q   <= rvalid_d;
         bresp_q    <= bresp_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
      end
   end

   assign CYC      = cyc_q;
   assign STB      = stb_q;
   assign WE       = we_q;
   assign ADDR     = addr_q;
   assign WB_WDATA = wb_wdata_q;
   assign SEL      = sel_q;
   assign BVALID   = bvalid_q;
   assign BRESP    = bresp_q;
   assign RVALID   = rvalid_q;
   assign RRESP    = rresp_q;
   assign RDATA    = rdata_q;

endmodule

// File: tb/tb_axi4lite2wb_bridge.sv
// Self-checking bench for axi4lite2wb_bridge: directed scenarios plus randomized
// transactions checked against a transaction-level expectation model.
module tb_axi4lite2wb_bridge;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rstn;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, araddr, wdata, rdata, addr, wb_wdata, wb_rdata;
   logic [3:0]  wstrb, sel;
   logic [2:0]  awprot, arprot;
   logic [1:0]  bresp, rresp;
   logic        cyc, stb, we, stall, ack, err;

   int n_tests = 0;
   int n_fail  = 0;
   bit exp_rd_prio;

   axi4lite2wb_bridge #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK(clk), .RSTN(rstn),
      .AWVALID(awvalid), .AWREADY(awready), .AWADDR(awaddr), .AWPROT(awprot),
      .WVALID(wvalid), .WREADY(wready), .WDATA(wdata), .WSTRB(wstrb),
      .BVALID(bvalid), .BREADY(bready), .BRESP(bresp),
      .ARVALID(arvalid), .ARREADY(arready), .ARADDR(araddr), .ARPROT(arprot),
      .RVALID(rvalid), .RREADY(rready), .RDATA(rdata), .RRESP(rresp),
      .CYC(cyc), .STB(stb), .WE(we), .ADDR(addr), .WB_WDATA(wb_wdata), .SEL(sel),
      .STALL(stall), .ACK(ack), .ERR(err), .WB_RDATA(wb_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_t, input int w_t, output bit ok);
      bit aw_done = 0, w_done = 0, aw_f, w_f;
      awaddr = a; wdata = d; wstrb = s;
      for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
         awvalid = !aw_done && c >= aw_t;
         wvalid  = !w_done && c >= w_t;
         #1;
         aw_f = awvalid & awready;
         w_f  = wvalid & wready;
         tick();
         aw_done |= aw_f;
         w_done  |= w_f;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      ok = aw_done && w_done;
   endtask

   task automatic axi_read(input logic [31:0] a, output bit ok);
      bit f = 0;
      araddr = a; arvalid = 1'b1;
      for (int c = 0; c < 20 && !f; c++) begin
         #1;
         f = arready;
         tick();
      end
      arvalid = 1'b0;
      ok = f;
   endtask

   // Wishbone slave: mode 0 ACK, 1 ERR, 2 silent, 3 ACK+ERR.
   task automatic wb_serve(input int stall_n, input int wait_n, input int mode,
                           input logic [31:0] rd, output bit seen, output logic g_we,
                           output logic [31:0] g_addr, output logic [31:0] g_wdata,
                           output logic [3:0] g_sel, output int stb_len, output int lat);
      seen = 0; stb_len = 0; lat = -1; g_we = 0; g_addr = 0; g_wdata = 0; g_sel = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (stb) seen = 1;
         else tick();
      end
      if (!seen) return;
      for (int i = 0; i < stall_n; i++) begin
         stall = 1'b1;
         if (stb) stb_len++;
         tick();
      end
      stall = 1'b0;
      if (stb) stb_len++;
      g_we = we; g_addr = addr; g_wdata = wb_wdata; g_sel = sel;
      tick();
      lat = 1;
      for (int i = 0; i < wait_n; i++) begin
         tick();
         lat++;
      end
      if (mode != 2) begin
         ack = (mode == 0 || mode == 3);
         err = (mode == 1 || mode == 3);
         wb_rdata = rd;
         tick();
         lat++;
         ack = 1'b0; err = 1'b0;
      end
      while (!(bvalid || rvalid) && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick(); tick();
      n_tests++;
      if ({cyc, stb, we, bvalid, rvalid} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 00000", {cyc, stb, we, bvalid, rvalid});
      end
      n_tests++;
      if (addr !== 0 || wb_wdata !== 0 || rdata !== 0 || sel !== 0 || bresp !== 0 || rresp !== 0)
      begin
         n_fail++;
         $display("FAIL reset_data: got addr %h wd %h rd %h sel %h br %b rr %b want all 0",
                  addr, wb_wdata, rdata, sel, bresp, rresp);
      end
      n_tests++;
      if ({awready, wready, arready} !== 3'b110) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 110", {awready, wready, arready});
      end
      arvalid = 1'b1;
      #1;
      n_tests++;
      if ({awready, wready, arready} !== 3'b001) begin
         n_fail++;
         $display("FAIL reset_arready: got %b want 001", {awready, wready, arready});
      end
      arvalid = 1'b0;
      tick();
      rstn = 1'b1;
      exp_rd_prio = 0;
      tick();
   endtask

   task automatic test_single_write();
      bit ok, seen; logic g_we; logic [31:0] g_a, g_d; logic [3:0] g_s; int sl, lat;
      axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 2, ok);
      n_tests++;
      if (!ok || {cyc, stb, we} !== 3'b111) begin
         n_fail++;
         $display("FAIL wr_start: got ok %0d cyc/stb/we %b want 1 111", ok, {cyc, stb, we});
      end
      n_tests++;
      if (addr !== 32'h10 || sel !== 4'hF || wb_wdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL wr_fields: got %h %h %h want 00000010 f deadbeef", addr, sel, wb_wdata);
      end
      wb_serve(0, 0, 0, 32'h0, seen, g_we, g_a, g_d, g_s, sl, lat);
      n_tests++;
      if (!seen || sl != 1 || lat != 2 || bvalid !== 1 || bresp !== 2'b00 || cyc !== 0) begin
         n_fail++;
         $display("FAIL wr_resp: got seen %0d stb %0d lat %0d bv %b br %b cyc %b want 1 1 2 1 00 0",
                  seen, sl, lat, bvalid, bresp, cyc);
      end
      bready = 1'b1; tick(); bready = 1'b0;
      n_tests++;
      if (bvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_bdone: got bvalid %b want 0", bvalid);
      end
      exp_rd_prio = 1;
   endtask

   task automatic test_read_stall();
      bit ok, seen; logic g_we; logic [31:0] g_a, g_d; logic [3:0] g_s; int sl, lat;
      axi_read(32'h24, ok);
      n_tests++;
      if (!ok || {cyc, stb, we} !== 3'b110 || sel !== 4'hF || addr !== 32'h24) begin
         n_fail++;
         $display("FAIL rd_start: got ok %0d %b sel %h addr %h want 1 110 f 24",
                  ok, {cyc, stb, we}, sel, addr);
      end
      wb_serve(3, 1, 0, 32'hCAFEF00D, seen, g_we, g_a, g_d, g_s, sl, lat);
      n_tests++;
      if (sl != 4 || lat != 3) begin
         n_fail++;
         $display("FAIL rd_stall_timing: got stb %0d lat %0d want 4 3", sl, lat);
      end
      n_tests++;
      if (rvalid !== 1 || rdata !== 32'hCAFEF00D || rresp !== 2'b00) begin
         n_fail++;
         $display("FAIL rd_resp: got %b %h %b want 1 cafef00d 00", rvalid, rdata, rresp);
      end
      rready = 1'b1; tick(); rready = 1'b0;
      exp_rd_prio = 0;
   endtask

   task automatic test_arbitration();
      bit ok, seen, aw_f, w_f, ar_f, exp_wr;
      logic g_we; logic [31:0] g_a, g_d; logic [3:0] g_s; int sl, lat;
      for (int k = 0; k < 4; k++) begin
         exp_wr = !exp_rd_prio;
         awaddr = 32'h100 + 32'(k * 4); araddr = 32'h200 + 32'(k * 4);
         wdata = $urandom; wstrb = 4'hF;
         awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
         #1;
         aw_f = awready; w_f = wready; ar_f = arready;
         tick();
         awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
         n_tests++;
         if ({aw_f, w_f, ar_f} !== {exp_wr, exp_wr, !exp_wr}) begin
            n_fail++;
            $display("FAIL arb_grant%0d: got %b want %b", k, {aw_f, w_f, ar_f},
                     {exp_wr, exp_wr, !exp_wr});
         end
         wb_serve(0, 0, 0, 32'h5A5A0000 + 32'(k), seen, g_we, g_a, g_d, g_s, sl, lat);
         n_tests++;
         if (g_we !== exp_wr || g_a !== (exp_wr ? 32'h100 : 32'h200) + 32'(k * 4)) begin
            n_fail++;
            $display("FAIL arb_order%0d: got we %b addr %h want we %b", k, g_we, g_a, exp_wr);
         end
         bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
         exp_rd_prio = exp_wr;
      end
   endtask

   task automatic test_err_timeout();
      bit ok, seen; logic g_we; logic [31:0] g_a, g_d; logic [3:0] g_s; int sl, lat;
      axi_write(32'h30, 32'h11112222, 4'h5, 0, 0, ok);
      wb_serve(0, 2, 1, 32'h0, seen, g_we, g_a, g_d, g_s, sl, lat);
      n_tests++;
      if (!ok || bvalid !== 1 || bresp !== 2'b10 || lat != 4) begin
         n_fail++;
         $display("FAIL wr_err: got ok %0d bv %b br %b lat %0d want 1 1 10 4",
                  ok, bvalid, bresp, lat);
      end
      bready = 1'b1; tick(); bready = 1'b0;
      exp_rd_prio = 1;
      axi_read(32'h34, ok);
      wb_serve(0, 0, 2, 32'h12345678, seen, g_we, g_a, g_d, g_s, sl, lat);
      n_tests++;
      if (!ok || rvalid !== 1 || rresp !== 2'b10 || rdata !== 0 || lat != int'(TO) + 1) begin
         n_fail++;
         $display("FAIL rd_timeout: got ok %0d rv %b rr %b rd %h lat %0d want 1 1 10 0 %0d",
                  ok, rvalid, rresp, rdata, lat, TO + 1);
      end
      rready = 1'b1; tick(); rready = 1'b0;
      exp_rd_prio = 0;
   endtask

   task automatic test_backpressure();
      bit ok, seen; logic g_we; logic [31:0] g_a, g_d, rd; logic [3:0] g_s; int sl, lat;
      rd = $urandom;
      axi_read(32'h40, ok);
      wb_serve(0, 0, 0, rd, seen, g_we, g_a, g_d, g_s, sl, lat);
      araddr = 32'h44; arvalid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_tests++;
         if (rvalid !== 1 || rdata !== rd || rresp !== 2'b00 || arready !== 0 || cyc !== 0)
         begin
            n_fail++;
            $display("FAIL bp_hold%0d: got rv %b rd %h rr %b ar %b cyc %b want 1 %h 00 0 0",
                     i, rvalid, rdata, rresp, arready, cyc, rd);
         end
         tick();
      end
      rready = 1'b1; tick(); rready = 1'b0;
      #1;
      n_tests++;
      if (rvalid !== 0 || arready !== 1) begin
         n_fail++;
         $display("FAIL bp_release: got rv %b ar %b want 0 1", rvalid, arready);
      end
      tick();
      arvalid = 1'b0;
      n_tests++;
      if (cyc !== 1 || addr !== 32'h44) begin
         n_fail++;
         $display("FAIL bp_next: got cyc %b addr %h want 1 44", cyc, addr);
      end
      wb_serve(0, 0, 0, 32'h0, seen, g_we, g_a, g_d, g_s, sl, lat);
      rready = 1'b1; tick(); rready = 1'b0;
      exp_rd_prio = 0;
   endtask

   task automatic test_reset_mid();
      bit ok, seen; logic g_we; logic [31:0] g_a, g_d, d2; logic [3:0] g_s; int sl, lat;
      axi_write(32'h50, 32'h0BADF00D, 4'h3, 1, 0, ok);
      stall = 1'b0;
      tick();
      n_tests++;
      if (!ok || cyc !== 1 || stb !== 0) begin
         n_fail++;
         $display("FAIL rst_wait: got ok %0d cyc %b stb %b want 1 1 0", ok, cyc, stb);
      end
      rstn = 1'b0;
      #1;
      n_tests++;
      if ({cyc, stb, we, bvalid, rvalid} !== 5'b0 || addr !== 0 || sel !== 0 || wb_wdata !== 0)
      begin
         n_fail++;
         $display("FAIL rst_async: got %b addr %h sel %h wd %h want 00000 0 0 0",
                  {cyc, stb, we, bvalid, rvalid}, addr, sel, wb_wdata);
      end
      tick();
      rstn = 1'b1; ack = 1'b1;
      exp_rd_prio = 0;
      tick();
      ack = 1'b0;
      tick();
      n_tests++;
      if (bvalid !== 0 || cyc !== 0) begin
         n_fail++;
         $display("FAIL rst_stray_ack: got bv %b cyc %b want 0 0", bvalid, cyc);
      end
      d2 = $urandom;
      axi_write(32'h54, d2, 4'hF, 0, 0, ok);
      wb_serve(0, 0, 0, 32'h0, seen, g_we, g_a, g_d, g_s, sl, lat);
      n_tests++;
      if (!ok || g_a !== 32'h54 || g_d !== d2 || bvalid !== 1 || bresp !== 0 || lat != 2) begin
         n_fail++;
         $display("FAIL rst_next_wr: got ok %0d addr %h data %h bv %b br %b lat %0d want 1 54 %h 1 00 2",
                  ok, g_a, g_d, bvalid, bresp, lat, d2);
      end
      bready = 1'b1; tick(); bready = 1'b0;
      exp_rd_prio = 1;
   endtask

   task automatic test_random();
      bit ok, seen, is_wr; logic g_we; logic [31:0] g_a, g_d, a, d, rd, exp_rd;
      logic [3:0] g_s, s, exp_s; logic [1:0] exp_resp; int sl, lat, mode, st, wt, r;
      for (int k = 0; k < 20; k++) begin
         is_wr = 1'($urandom_range(0, 1));
         a = $urandom & 32'hFFFF_FFFC; d = $urandom; rd = $urandom; s = 4'($urandom);
         r = $urandom_range(0, 9);
         mode = (r < 6) ? 0 : (r < 8) ? 1 : 3;
         st = $urandom_range(0, 3); wt = $urandom_range(0, 5);
         if (is_wr) axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), ok);
         else       axi_read(a, ok);
         wb_serve(st, wt, mode, rd, seen, g_we, g_a, g_d, g_s, sl, lat);
         exp_s    = is_wr ? s : 4'hF;
         exp_resp = (mode == 0) ? 2'b00 : 2'b10;
         exp_rd   = (mode == 0) ? rd : 32'h0;
         n_tests++;
         if (!ok || !seen || g_we !== is_wr || g_a !== a || g_s !== exp_s ||
             (is_wr && g_d !== d)) begin
            n_fail++;
            $display("FAIL rnd_req%0d: got we %b addr %h sel %h wd %h want %b %h %h %h",
                     k, g_we, g_a, g_s, g_d, is_wr, a, exp_s, d);
         end
         n_tests++;
         if (sl != st + 1 || lat != wt + 2) begin
            n_fail++;
            $display("FAIL rnd_timing%0d: got stb %0d lat %0d want %0d %0d",
                     k, sl, lat, st + 1, wt + 2);
         end
         n_tests++;
         if (is_wr ? (bvalid !== 1 || bresp !== exp_resp)
                   : (rvalid !== 1 || rresp !== exp_resp || rdata !== exp_rd)) begin
            n_fail++;
            $display("FAIL rnd_resp%0d: got bv %b br %b rv %b rr %b rd %h want resp %b rd %h",
                     k, bvalid, bresp, rvalid, rresp, rdata, exp_resp, exp_rd);
         end
         for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
         bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
         exp_rd_prio = is_wr;
      end
   endtask

   initial begin
      rstn = 1'b0;
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
      awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 0; arprot = 0;
      stall = 0; ack = 0; err = 0; wb_rdata = 0;
      test_reset();
      test_single_write();
      test_read_stall();
      test_arbitration();
      test_err_timeout();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
